// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store requests into aligned word accesses,
// splitting boundary-crossing halfword/word accesses into two memory cycles.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [31:0] instruction,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_fault,
    output logic        dmem_en,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata
);
    // state | meaning
    // IDLE  | waiting for a request; stall follows the request combinationally
    // ACC0  | first (or only) word access
    // ACC1  | second word of a split access; ACC0 read word captured
    // DONE  | result/fault presented for one cycle, core released
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] addr_q, data_q, buf_q;
    logic [2:0]  f3_q;
    logic        store_q;

    logic        req, legal_in, legal_q, split;
    logic [1:0]  off;
    logic [2:0]  size_n;
    logic [3:0]  lane_mask;
    logic [7:0]  wide_mask;
    logic [63:0] wide_data, shifted;
    logic [31:0] word_addr, lo_word, hi_word, ext_data;

    function automatic logic is_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    assign req      = (mem_read | mem_write) & ~rst;
    assign legal_in = is_legal(mem_write, instruction[14:12]);
    assign legal_q  = is_legal(store_q, f3_q);
    assign off      = addr_q[1:0];

    always_comb begin
        size_n    = 3'd4;
        lane_mask = 4'b1111;
        case (f3_q[1:0])
            2'b00: begin size_n = 3'd1; lane_mask = 4'b0001; end
            2'b01: begin size_n = 3'd2; lane_mask = 4'b0011; end
            default: ;
        endcase
    end

    assign split     = ({1'b0, off} + size_n) > 3'd4;
    assign wide_data = {32'b0, data_q} << {off, 3'b000};
    assign wide_mask = {4'b0, lane_mask} << off;
    assign word_addr = {addr_q[31:2], 2'b00};

    // Split loads see the ACC0 word in the buffer and the ACC1 word on the bus.
    assign lo_word = split ? buf_q : dmem_rdata;
    assign hi_word = split ? dmem_rdata : 32'b0;
    assign shifted = {hi_word, lo_word} >> {off, 3'b000};

    always_comb begin
        ext_data = 32'b0;
        case (f3_q)
            3'b000: ext_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001: ext_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010: ext_data = shifted[31:0];
            3'b100: ext_data = {24'b0, shifted[7:0]};
            3'b101: ext_data = {16'b0, shifted[15:0]};
            default: ext_data = 32'b0;
        endcase
    end

    always_comb begin
        state_nx     = state;
        stall        = 1'b0;
        load_data    = 32'b0;
        load_valid   = 1'b0;
        access_fault = 1'b0;
        dmem_en      = 1'b0;
        dmem_we      = 4'b0;
        dmem_addr    = 32'b0;
        dmem_wdata   = 32'b0;
        case (state)
            IDLE: begin
                stall = req;
                if (req)
                    state_nx = legal_in ? ACC0 : DONE;
            end
            ACC0: begin
                stall      = 1'b1;
                dmem_en    = 1'b1;
                dmem_addr  = word_addr;
                dmem_we    = store_q ? wide_mask[3:0] : 4'b0;
                dmem_wdata = store_q ? wide_data[31:0] : 32'b0;
                state_nx   = split ? ACC1 : DONE;
            end
            ACC1: begin
                stall      = 1'b1;
                dmem_en    = 1'b1;
                dmem_addr  = word_addr + 32'd4;
                dmem_we    = store_q ? wide_mask[7:4] : 4'b0;
                dmem_wdata = store_q ? wide_data[63:32] : 32'b0;
                state_nx   = DONE;
            end
            DONE: begin
                access_fault = ~legal_q;
                load_valid   = legal_q & ~store_q;
                load_data    = (legal_q & ~store_q) ? ext_data : 32'b0;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= 32'b0;
            data_q  <= 32'b0;
            buf_q   <= 32'b0;
            f3_q    <= 3'b0;
            store_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req) begin
                addr_q  <= alu_result;
                data_q  <= rs2_data;
                f3_q    <= instruction[14:12];
                store_q <= mem_write;
            end
            if (state == ACC1)
                buf_q <= dmem_rdata;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{instruction[31:15], instruction[11:0], shifted[63:32]};
endmodule
